uart_debug: RTL and testbench
=============================

UART_DEBUG -- requirements
Module: uart_debug

Interface
REQ-001 Parameter CLK_FREQ, default 50_000_000; input clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200; serial bit rate in bit/s.
REQ-003 Parameter GAP_BITS, default 1; idle bit-times of mark (tx=1) inserted after each stop bit, range 0..15.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 data  input  8  byte transmitted repeatedly.
REQ-007 tx  output  1  UART serial line, idle-high, driven directly from a flop.

Function
REQ-008 CLKS_PER_BIT SHALL be CLK_FREQ/BAUD, truncated (434 at defaults); a compile-time check SHALL reject values below 2.
REQ-009 The bit-period counter SHALL be $clog2(CLKS_PER_BIT) bits wide and count 0..CLKS_PER_BIT-1; each bit SHALL last exactly CLKS_PER_BIT cycles.
REQ-010 FSM states SHALL be IDLE, START, DATA, PARITY (macro only), STOP and GAP.
REQ-011 IDLE SHALL last one cycle, latch data into a shift register, drive tx=0 and move to START.
REQ-012 START SHALL hold tx=0 for one bit period, then move to DATA.
REQ-013 DATA SHALL send the 8 latched bits LSB first, one bit per bit period, using a 3-bit index, then move to PARITY or STOP.
REQ-014 STOP SHALL hold tx=1 for one bit period, then move to GAP, or to IDLE if GAP_BITS=0.
REQ-015 GAP SHALL hold tx=1 for GAP_BITS bit periods, then move to IDLE.
REQ-016 Frames SHALL repeat indefinitely; frame period SHALL be 1 + (10 + GAP_BITS)*CLKS_PER_BIT cycles (4775 at defaults, +CLKS_PER_BIT with parity).
REQ-017 A change on data during a frame SHALL NOT affect that frame; the new value SHALL be sent from the next IDLE latch onward.
REQ-018 tx SHALL change only on bit-period boundaries and SHALL be glitch-free.

Reset
REQ-019 While rst_n=0 at a rising edge: tx=1, state=IDLE, all counters and the shift register cleared.
REQ-020 Reset asserted mid-frame SHALL abort the frame, with tx=1 from the next edge.
REQ-021 On the first edge with rst_n=1, IDLE SHALL execute and tx SHALL fall at that edge (start bit).

Configuration
REQ-022 With UART_DEBUG_PARITY_EN defined, a PARITY state SHALL follow DATA and send one bit period of even parity (XOR of the 8 latched bits); frames are 11 bits.
REQ-023 Without UART_DEBUG_PARITY_EN, PARITY logic SHALL NOT be compiled and frames are 10 bits (8N1).

Structure
REQ-024 A package uart_debug_pkg SHALL hold the state enum typedef and the bit-count constants (DATA_BITS=8, STOP_BITS=1).
REQ-025 One sub-module, uart_debug_baud_tick, SHALL generate the one-cycle bit-period tick from CLKS_PER_BIT, restartable by the FSM at each frame start.

Verification
REQ-026 Bench clock SHALL be 50 MHz (20 ns period); rst_n=0 until 100 ns; data=8'h41 -> tx=1 during reset; tx falls at 110 ns; bits sampled mid-period read 0,1,0,0,0,0,0,1,0,1 (start, LSB-first 0x41, stop).
REQ-027 Run 300 us with data=8'h41 -> at least 3 complete frames, start-bit falling edges exactly 4775 cycles apart, each decoding to 0x41.
REQ-028 Change data to 8'hA5 mid-DATA of frame N -> frame N decodes 0x41, frame N+1 decodes 0xA5.
REQ-029 Assert rst_n=0 for 3 cycles during DATA -> tx=1 from the next edge; a new complete frame starts on the first edge after release.
REQ-030 Define UART_DEBUG_PARITY_EN, data=8'h41 -> parity bit 0, frame period 5209 cycles; data=8'h01 -> parity bit 1.
REQ-031 Measure every bit width over 3 frames -> each exactly 434 cycles; GAP high for 434 cycles.

Source files
------------

// File: rtl/uart_debug_pkg.sv
// Shared types and constants for the uart_debug transmitter.
// The PARITY state and parity helper exist only when UART_DEBUG_PARITY_EN is defined.
package uart_debug_pkg;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef UART_DEBUG_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP,
    ST_GAP
  } state_e;

`ifdef UART_DEBUG_PARITY_EN
  function automatic logic even_parity(input logic [DATA_BITS-1:0] bits);
    return ^bits;
  endfunction
`endif

endpackage

// File: rtl/uart_debug_baud_tick.sv
// Bit-period timer: pulses tick_o for one cycle every CLKS_PER_BIT cycles.
// restart_i realigns the period so a frame's start bit gets a full bit time.
module uart_debug_baud_tick #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic restart_i,
  output logic tick_o
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: wrap at the last cycle of the period or on restart.
  always_comb begin
    cnt_d = cnt_q;
    if (restart_i) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (cnt_q == CNT_LAST) begin
      cnt_d = {CNT_W{1'b0}};
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = (cnt_q == CNT_LAST);

endmodule

// File: rtl/uart_debug.sv
// Free-running UART transmitter that repeatedly sends the byte on data (8N1).
// Defining UART_DEBUG_PARITY_EN adds an even-parity bit (8E1).
module uart_debug
  import uart_debug_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115200,
  parameter int GAP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data,
  output logic       tx
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam logic [3:0] GAP_LAST = 4'((GAP_BITS == 0) ? 0 : GAP_BITS - 1);
  localparam logic [2:0] IDX_LAST = 3'(DATA_BITS - 1);

  if (CLKS_PER_BIT < 2) begin : g_bad_cpb
    $error("uart_debug: CLK_FREQ/BAUD must be at least 2");
  end
  if (GAP_BITS < 0 || GAP_BITS > 15) begin : g_bad_gap
    $error("uart_debug: GAP_BITS must be in 0..15");
  end
  if (STOP_BITS != 1) begin : g_bad_stop
    $error("uart_debug: only one stop bit is supported");
  end

  state_e                 state_q, state_d;
  logic                   tx_q, tx_d;
  logic [DATA_BITS-1:0]   shreg_q, shreg_d;
  logic [2:0]             bit_idx_q, bit_idx_d;
  logic [3:0]             gap_q, gap_d;
  logic                   restart_s;
  logic                   tick_s;

  uart_debug_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_tick (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .restart_i(restart_s),
    .tick_o   (tick_s)
  );

  // Frame sequencing; tx_d is the line level for the period starting at the next edge.
  always_comb begin
    state_d   = state_q;
    tx_d      = tx_q;
    shreg_d   = shreg_q;
    bit_idx_d = bit_idx_q;
    gap_d     = gap_q;
    restart_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        shreg_d   = data;
        tx_d      = 1'b0;
        bit_idx_d = 3'd0;
        gap_d     = 4'd0;
        restart_s = 1'b1;
        state_d   = ST_START;
      end
      ST_START: begin
        if (tick_s) begin
          tx_d    = shreg_q[0];
          state_d = ST_DATA;
        end else begin
          state_d = ST_START;
        end
      end
      ST_DATA: begin
        if (tick_s) begin
          if (bit_idx_q == IDX_LAST) begin
`ifdef UART_DEBUG_PARITY_EN
            tx_d    = even_parity(shreg_q);
            state_d = ST_PARITY;
`else
            tx_d    = 1'b1;
            state_d = ST_STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            tx_d      = shreg_q[bit_idx_q + 3'd1];
          end
        end else begin
          state_d = ST_DATA;
        end
      end
`ifdef UART_DEBUG_PARITY_EN
      ST_PARITY: begin
        if (tick_s) begin
          tx_d    = 1'b1;
          state_d = ST_STOP;
        end else begin
          state_d = ST_PARITY;
        end
      end
`endif
      ST_STOP: begin
        if (tick_s) begin
          gap_d   = 4'd0;
          state_d = (GAP_BITS == 0) ? ST_IDLE : ST_GAP;
        end else begin
          state_d = ST_STOP;
        end
      end
      ST_GAP: begin
        if (tick_s) begin
          if (gap_q == GAP_LAST) begin
            state_d = ST_IDLE;
          end else begin
            gap_d = gap_q + 4'd1;
          end
        end else begin
          state_d = ST_GAP;
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset parks the line at mark.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      tx_q      <= 1'b1;
      shreg_q   <= {DATA_BITS{1'b0}};
      bit_idx_q <= 3'd0;
      gap_q     <= 4'd0;
    end else begin
      state_q   <= state_d;
      tx_q      <= tx_d;
      shreg_q   <= shreg_d;
      bit_idx_q <= bit_idx_d;
      gap_q     <= gap_d;
    end
  end

  assign tx = tx_q;

endmodule

// File: tb/tb_uart_debug.sv
// Self-checking bench for uart_debug: cycle-level line model, independent frame decoder,
// directed reset/data-change scenarios and randomized data/reset stimulus.
module tb_uart_debug;

  localparam int CLK_FREQ = 50_000_000;
  localparam int BAUD     = 115200;
  localparam int GAP      = 1;
  localparam int CPB      = CLK_FREQ / BAUD;
`ifdef UART_DEBUG_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int NBITS = PAR ? 11 : 10;
  localparam int P     = 1 + (NBITS + GAP) * CPB;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] data;
  logic       tx;

  int n_cmp = 0;
  int n_bad = 0;

  uart_debug #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .GAP_BITS(GAP)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .data (data),
    .tx   (tx)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference line level for a given offset within a frame.
  function automatic logic frame_bit(input logic [7:0] b, input int off);
    int k;
    k = off / CPB;
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    if (PAR && k == 9) return ^b;
    return 1'b1;
  endfunction

  int         cyc = 0;
  int         m_off = -1;
  logic       m_tx = 1'b1;
  logic       m_rst = 1'b1;
  logic [7:0] m_byte = 8'h00;
  logic [7:0] exp_by_start [int];
  logic [7:0] rx_q [$];

  // Model: frames back to back of P cycles, byte captured at each frame start.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (rst_n !== 1'b1) begin
        m_off = -1;
        m_tx  = 1'b1;
        m_rst = 1'b1;
      end else begin
        m_rst = 1'b0;
        if (m_off < 0 || m_off == P - 1) begin
          m_off  = 0;
          m_byte = data;
          exp_by_start[cyc] = data;
        end else begin
          m_off++;
        end
        m_tx = frame_bit(m_byte, m_off);
      end
    end
  end

  // Per-cycle line check plus a mid-bit sampling decoder.
  initial begin
    logic       d_act = 1'b0, d_prev = 1'b1, d_rst = 1'b0, d_have_last = 1'b0;
    int         d_start = 0, d_last = 0, o, k;
    logic [7:0] d_byte = 8'h00;
    forever begin
      @(negedge clk);
      if (cyc > 0) check("tx_cycle", tx, m_tx);
      if (m_rst) begin
        d_act = 1'b0;
        d_rst = 1'b1;
      end else if (!d_act) begin
        if (d_prev && !tx) begin
          d_act   = 1'b1;
          d_start = cyc;
        end
      end else begin
        o = cyc - d_start;
        if (o % CPB == CPB / 2) begin
          k = o / CPB;
          if (k == 0) begin
            check("start_bit", tx, 1'b0);
          end else if (k <= 8) begin
            d_byte[k-1] = tx;
          end else if (PAR && k == 9) begin
            check("parity_bit", tx, ^d_byte);
          end else begin
            check("stop_bit", tx, 1'b1);
            rx_q.push_back(d_byte);
            check("frame_known", exp_by_start.exists(d_start), 1'b1);
            if (exp_by_start.exists(d_start)) check("frame_byte", d_byte, exp_by_start[d_start]);
            if (d_have_last && !d_rst) check("frame_period", d_start - d_last, P);
            d_last      = d_start;
            d_have_last = 1'b1;
            d_rst       = 1'b0;
            d_act       = 1'b0;
          end
        end
      end
      d_prev = tx;
    end
  end

  task automatic wait_frames(input int n, input int budget);
    int c = 0;
    while (rx_q.size() < n && c < budget) begin
      @(posedge clk);
      c++;
    end
    check("frame_timeout", rx_q.size() >= n, 1'b1);
  endtask

  task automatic wait_off(input int target, input int budget);
    int c = 0;
    do begin
      @(posedge clk);
      #1;
      c++;
    end while (m_off != target && c < budget);
    check("offset_timeout", m_off == target, 1'b1);
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    data  = 8'h41;
    #45;
    check("reset_tx", tx, 1'b1);
    #55;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("first_fall", tx, 1'b0);
    check("first_fall_time", $time, 111);

    wait_frames(3, 4 * P);
    for (int i = 0; i < 3; i++)
      check("steady_byte", (rx_q.size() > i) ? rx_q[i] : 9'h100, 8'h41);

    // Data change in the middle of the data bits.
    wait_off(4 * CPB + CPB / 2, 2 * P);
    data = 8'hA5;
    n = rx_q.size();
    wait_frames(n + 2, 3 * P);
    check("chg_frame_n",  (rx_q.size() > n)     ? rx_q[n]     : 9'h100, 8'h41);
    check("chg_frame_n1", (rx_q.size() > n + 1) ? rx_q[n + 1] : 9'h100, 8'hA5);

    // Three-cycle reset during the data bits.
    wait_off(5 * CPB + 7, 2 * P);
    rst_n = 1'b0;
    cycles(1);
    check("mid_reset_tx", tx, 1'b1);
    cycles(2);
    rst_n = 1'b1;
    n = rx_q.size();
    cycles(1);
    check("release_fall", tx, 1'b0);
    wait_frames(n + 1, 2 * P);
    check("post_reset_byte", (rx_q.size() > n) ? rx_q[n] : 9'h100, 8'hA5);

    // Random data changes and occasional short resets, checked by the model.
    for (int it = 0; it < 5; it++) begin
      cycles($urandom_range(50, P));
      data = 8'($urandom);
      if ($urandom_range(0, 2) == 0) begin
        rst_n = 1'b0;
        cycles($urandom_range(1, 4));
        rst_n = 1'b1;
      end
    end
    n = rx_q.size();
    wait_frames(n + 2, 3 * P);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
